// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO of (pc, instr)
// pairs with valid/ready on both sides and a single-cycle flush for redirects.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          push;
    logic          pop;
    logic [PW:0]   count_next;

    // Handshake outputs come only from registered state, so neither side sees
    // a combinational path through the queue.
    always_comb begin
        in_ready  = (count != FULL_COUNT);
        out_valid = (count != '0);
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = mem[rp][63:32];
            out_instr = mem[rp][31:0];
        end
    end

    always_comb begin
        push       = in_valid & in_ready & ~flush;
        pop        = out_valid & out_ready & ~flush;
        count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) begin
                    wp <= wp + 1'b1;
                end
                if (pop) begin
                    rp <= rp + 1'b1;
                end
            end
        end
    end

    // Payload storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= {in_pc, in_instr};
        end
    end

endmodule
